// File: rtl/up5bit_counter_scheduler.sv
// Two counter channels sharing one incrementer under a round-robin arbiter.
// Optional saturation at all-ones: define UP5BIT_SCHED_SATURATE_EN.
module up5bit_counter_scheduler #(
    parameter int WIDTH = 5,
    parameter int INIT0 = 1,
    parameter int INIT1 = 0
) (
    input  logic             clk,
    input  logic             global_resetn,
    input  logic [1:0]       req,
    input  logic [1:0]       load,
    input  logic [WIDTH-1:0] load_val0,
    input  logic [WIDTH-1:0] load_val1,
    output logic [1:0]       gnt,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [1:0]       wrap
);

    logic [WIDTH-1:0] r_out0;
    logic [WIDTH-1:0] r_out1;
    logic [1:0]       r_gnt;
    logic [1:0]       r_wrap;
    logic             r_lg;

    logic [1:0]       w_elig;
    logic [1:0]       w_gnt;
    logic             w_sel;
    logic [WIDTH-1:0] w_cur;
    logic             w_max;
    logic [WIDTH-1:0] w_next;

    // A channel granted last cycle or being loaded sits this cycle out.
    assign w_elig = req & ~r_gnt & ~load;

    always_comb begin
        w_gnt = 2'b00;
        unique case (1'b1)
            (w_elig == 2'b11): w_gnt = r_lg ? 2'b01 : 2'b10;
            (w_elig == 2'b01): w_gnt = 2'b01;
            (w_elig == 2'b10): w_gnt = 2'b10;
            default:           w_gnt = 2'b00;
        endcase
    end

    assign w_sel = w_gnt[1];
    assign w_cur = w_sel ? r_out1 : r_out0;
    assign w_max = &w_cur;

`ifdef UP5BIT_SCHED_SATURATE_EN
    assign w_next = w_max ? w_cur : w_cur + WIDTH'(1);
`else
    assign w_next = w_cur + WIDTH'(1);
`endif

    always_ff @(posedge clk or negedge global_resetn) begin
        if (!global_resetn) begin
            r_out0 <= WIDTH'(INIT0);
            r_out1 <= WIDTH'(INIT1);
            r_gnt  <= 2'b00;
            r_wrap <= 2'b00;
            r_lg   <= 1'b1;
        end else begin
            r_gnt  <= w_gnt;
            r_wrap <= w_gnt & {2{w_max}};
            if (|w_gnt) begin
                r_lg <= w_sel;
            end
            if (load[0]) begin
                r_out0 <= load_val0;
            end else if (w_gnt[0]) begin
                r_out0 <= w_next;
            end
            if (load[1]) begin
                r_out1 <= load_val1;
            end else if (w_gnt[1]) begin
                r_out1 <= w_next;
            end
        end
    end

    assign gnt  = r_gnt;
    assign wrap = r_wrap;
    assign out0 = r_out0;
    assign out1 = r_out1;

endmodule

// File: tb/tb_up5bit_counter_scheduler.sv
// Bench for up5bit_counter_scheduler: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_up5bit_counter_scheduler;

    localparam int MAXV = 31;

    logic       clk;
    logic       global_resetn;
    logic [1:0] req;
    logic [1:0] load;
    logic [4:0] load_val0;
    logic [4:0] load_val1;
    logic [1:0] gnt;
    logic [4:0] out0;
    logic [4:0] out1;
    logic [1:0] wrap;

    int n_checks;
    int n_fail;

    int         m_cnt[2];
    int         m_lg;
    logic [1:0] m_gnt;
    logic [1:0] m_wrap;

    up5bit_counter_scheduler dut (
        .clk(clk),
        .global_resetn(global_resetn),
        .req(req),
        .load(load),
        .load_val0(load_val0),
        .load_val1(load_val1),
        .gnt(gnt),
        .out0(out0),
        .out1(out1),
        .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_cnt[0] = 1;
        m_cnt[1] = 0;
        m_lg     = 1;
        m_gnt    = 2'b00;
        m_wrap   = 2'b00;
    endtask

    // Advance model from the current inputs, then clock the DUT.
    task automatic tick();
        int el[$];
        int g;
        logic [1:0] ng;
        logic [1:0] nw;
        int lv[2];
        lv[0] = int'(load_val0);
        lv[1] = int'(load_val1);
        ng = 2'b00;
        nw = 2'b00;
        g  = -1;
        for (int i = 0; i < 2; i++)
            if (req[i] && !m_gnt[i] && !load[i]) el.push_back(i);
        if (el.size() == 1) g = el[0];
        else if (el.size() == 2) g = 1 - m_lg;
        if (g >= 0) begin
            ng[g] = 1'b1;
            if (m_cnt[g] == MAXV) begin
                nw[g] = 1'b1;
`ifdef UP5BIT_SCHED_SATURATE_EN
                m_cnt[g] = MAXV;
`else
                m_cnt[g] = 0;
`endif
            end else begin
                m_cnt[g] = m_cnt[g] + 1;
            end
            m_lg = g;
        end
        for (int i = 0; i < 2; i++)
            if (load[i]) m_cnt[i] = lv[i];
        m_gnt  = ng;
        m_wrap = nw;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        global_resetn = 1'b0;
        req  = 2'b00;
        load = 2'b00;
        @(posedge clk);
        #1;
        global_resetn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        global_resetn = 1'b0;
        req = 2'b00;
        load = 2'b00;
        load_val0 = '0;
        load_val1 = '0;
        repeat (2) @(posedge clk);
        #1;
        global_resetn = 1'b1;
        model_reset();
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if ({out0, out1, gnt, wrap} !== {5'd1, 5'd0, 2'b00, 2'b00}) begin
                n_fail++;
                $display("FAIL reset_idle c=%0d got out0=%0d out1=%0d gnt=%b wrap=%b want 1 0 00 00",
                         c, out0, out1, gnt, wrap);
            end
        end
    endtask

    task automatic test_lone_ch0();
        int wraps;
        reset_dut();
        wraps = 0;
        req = 2'b01;
        for (int c = 0; c < 64; c++) begin
            tick();
            if (wrap[0]) begin
                wraps++;
                n_checks++;
                if (out0 !== 5'd0) begin
                    n_fail++;
                    $display("FAIL lone_wrap_at_zero got out0=%0d want 0", out0);
                end
            end
            n_checks++;
            if ({out0, out1, gnt, wrap} !== {5'(m_cnt[0]), 5'(m_cnt[1]), m_gnt, m_wrap}) begin
                n_fail++;
                $display("FAIL lone_ch0 c=%0d got %0d %0d %b %b want %0d %0d %b %b",
                         c, out0, out1, gnt, wrap, m_cnt[0], m_cnt[1], m_gnt, m_wrap);
            end
        end
        req = 2'b00;
        n_checks++;
        if (wraps != 1 || out0 !== 5'd1 || out1 !== 5'd0) begin
            n_fail++;
            $display("FAIL lone_end got wraps=%0d out0=%0d out1=%0d want 1 1 0", wraps, out0, out1);
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        req = 2'b11;
        for (int c = 0; c < 64; c++) begin
            tick();
            n_checks++;
            if (gnt !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL alt_grant c=%0d got gnt=%b want %b", c, gnt,
                         (c % 2 == 0) ? 2'b01 : 2'b10);
            end
            n_checks++;
            if ({out0, out1, gnt, wrap} !== {5'(m_cnt[0]), 5'(m_cnt[1]), m_gnt, m_wrap}) begin
                n_fail++;
                $display("FAIL both c=%0d got %0d %0d %b %b want %0d %0d %b %b",
                         c, out0, out1, gnt, wrap, m_cnt[0], m_cnt[1], m_gnt, m_wrap);
            end
        end
        req = 2'b00;
        n_checks++;
        if (out0 !== 5'd1 || out1 !== 5'd0) begin
            n_fail++;
            $display("FAIL both_end got out0=%0d out1=%0d want 1 0", out0, out1);
        end
    endtask

    task automatic test_conflict();
        reset_dut();
        req = 2'b11;
        load = 2'b01;
        load_val0 = 5'd7;
        tick();
        load = 2'b00;
        n_checks++;
        if ({out0, out1, gnt, wrap} !== {5'd7, 5'd1, 2'b10, 2'b00}) begin
            n_fail++;
            $display("FAIL conflict_load got %0d %0d %b %b want 7 1 10 00", out0, out1, gnt, wrap);
        end
        tick();
        req = 2'b00;
        n_checks++;
        if ({out0, gnt} !== {5'd8, 2'b01}) begin
            n_fail++;
            $display("FAIL conflict_next got out0=%0d gnt=%b want 8 01", out0, gnt);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        load = 2'b11;
        load_val0 = 5'd17;
        load_val1 = 5'd17;
        tick();
        n_checks++;
        if ({out0, out1, gnt} !== {5'd17, 5'd17, 2'b00}) begin
            n_fail++;
            $display("FAIL both_load got %0d %0d %b want 17 17 00", out0, out1, gnt);
        end
        load = 2'b00;
        req = 2'b11;
        #3;
        global_resetn = 1'b0;
        #1;
        n_checks++;
        if ({out0, out1, gnt, wrap} !== {5'd1, 5'd0, 2'b00, 2'b00}) begin
            n_fail++;
            $display("FAIL async_reset got %0d %0d %b %b want 1 0 00 00", out0, out1, gnt, wrap);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({out0, out1, gnt} !== {5'd1, 5'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL in_reset got %0d %0d %b want 1 0 00", out0, out1, gnt);
        end
        req = 2'b00;
        global_resetn = 1'b1;
        model_reset();
    endtask

    task automatic test_top_value();
        reset_dut();
        load = 2'b10;
        load_val1 = 5'd31;
        tick();
        load = 2'b00;
        req = 2'b10;
        tick();
        req = 2'b00;
        n_checks++;
`ifdef UP5BIT_SCHED_SATURATE_EN
        if ({out1, gnt, wrap} !== {5'd31, 2'b10, 2'b10}) begin
            n_fail++;
            $display("FAIL saturate got out1=%0d gnt=%b wrap=%b want 31 10 10", out1, gnt, wrap);
        end
`else
        if ({out1, gnt, wrap} !== {5'd0, 2'b10, 2'b10}) begin
            n_fail++;
            $display("FAIL wrap_ch1 got out1=%0d gnt=%b wrap=%b want 0 10 10", out1, gnt, wrap);
        end
`endif
        tick();
        n_checks++;
        if ({gnt, wrap} !== 4'b0000) begin
            n_fail++;
            $display("FAIL pulse_clear got gnt=%b wrap=%b want 00 00", gnt, wrap);
        end
    endtask

    task automatic test_random();
        reset_dut();
        for (int c = 0; c < 600; c++) begin
            req = 2'($urandom_range(0, 3));
            load[0] = ($urandom_range(0, 9) == 0);
            load[1] = ($urandom_range(0, 9) == 0);
            load_val0 = 5'($urandom);
            load_val1 = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom);
            tick();
            n_checks++;
            if ({out0, out1, gnt, wrap} !== {5'(m_cnt[0]), 5'(m_cnt[1]), m_gnt, m_wrap}) begin
                n_fail++;
                $display("FAIL random c=%0d got %0d %0d %b %b want %0d %0d %b %b",
                         c, out0, out1, gnt, wrap, m_cnt[0], m_cnt[1], m_gnt, m_wrap);
            end
        end
        req = 2'b00;
        load = 2'b00;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_lone_ch0();
        test_back_to_back();
        test_conflict();
        test_reset_mid();
        test_top_value();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
